data_mem_unit: RTL and testbench
================================

# data_mem_unit

Parametrised, handshaked data memory for the Titan processor datapath; successor to the single-port flat data RAM. Adds byte-lane write enables, a registered read port with valid/ready flow control on both request and response, out-of-range address detection, and a hardware clear engine that zeroes the whole array after reset or on command. It sits between the load/store stage and the word-addressed data array.

## Interface
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- RAM_ADDR_BITS, 12, address bits decoded into the array; DEPTH = 2**RAM_ADDR_BITS words.
- ADDR_WIDTH, 14, width of the incoming word address; must be >= RAM_ADDR_BITS.
- clk  in  1  single system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  WIDTH  write data.
- req_be  in  WIDTH/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  request address out of range.
- clear_start  in  1  request full-array clear.
- busy  out  1  clear engine running.

## Operation
- States: CLEAR, IDLE. Reset (rst_n low) forces CLEAR with clear counter = 0.
- CLEAR: one word per cycle, word[counter] <= 0, counter increments; at counter = DEPTH-1 the write completes and the next state is IDLE. busy = 1, req_ready = 0 throughout.
- IDLE: busy = 0. clear_start = 1 → next state CLEAR, counter = 0; req_ready forced 0 in that cycle.
- req_ready = (state == IDLE) && !clear_start && (!rsp_valid || rsp_ready).
- Accept = req_valid && req_ready. An accepted request always produces exactly one response.
- Range check: in range iff req_addr[ADDR_WIDTH-1:RAM_ADDR_BITS] == 0. When ADDR_WIDTH == RAM_ADDR_BITS, every address is in range.
- Write accept, in range: lanes with req_be[i] = 1 are updated and the other lanes are retained. Response: rsp_data = 0, rsp_err = 0.
- Write accept, out of range: the array is not modified. Response: rsp_err = 1, rsp_data = 0.
- Read accept, in range: rsp_data = word[req_addr[RAM_ADDR_BITS-1:0]] as of the accept edge, including any write accepted on an earlier cycle. rsp_err = 0.
- Read accept, out of range: rsp_data = 0, rsp_err = 1.
- Response register: loaded on accept. Held stable while rsp_valid && !rsp_ready. Cleared (rsp_valid = 0) on rsp_ready when no new accept occurs in the same cycle.
- Simultaneous response consume and new accept: the register reloads and rsp_valid stays 1.
- A pending response survives entry into CLEAR and is not altered by the clear.
- req_be = 0 on a write performs no modification but still returns a response.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_err 0, busy 1, req_ready 0, state CLEAR, counter 0.
- Post-reset clear takes DEPTH cycles. busy falls and req_ready rises DEPTH cycles after the first clock edge with rst_n high.
- Request-to-response latency: 1 cycle. rsp_valid rises on the edge that accepts the request.
- Throughput: 1 request per cycle while rsp_ready = 1.
- Read-after-write to the same address on back-to-back cycles returns the new data.
- rst_n asserted mid-clear or mid-transaction: immediately returns to reset values and restarts the clear. The pending response is dropped, and any in-flight write is not guaranteed.
- clear_start while busy is ignored; the counter is not restarted.

## Test plan
- Reset release: DEPTH cycles later busy = 0 and req_ready = 1. Read addresses 0, 1 and DEPTH-1 → rsp_data = 0, rsp_err = 0.
- Write 0xDEADBEEF to address 5 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read address 5 → 0xDEADBEAA, 1-cycle latency.
- Read address 0x1000 with ADDR_WIDTH = 14, RAM_ADDR_BITS = 12 → rsp_err = 1, rsp_data = 0. Write 0x12345678 to address 0x1005, then read address 0x005 → unchanged value, rsp_err = 0.
- Hold rsp_ready = 0 for 3 cycles after a read of 0xCAFE0001: rsp_data stays stable and req_ready = 0. Release → one response consumed, and the next request is accepted in that same cycle.
- Write 0x11 to address 7, pulse clear_start, wait DEPTH cycles, read address 7 → 0. clear_start pulsed again while busy → clear duration unchanged.
- Assert rst_n low mid-clear at counter = 100 → busy stays 1, rsp_valid = 0, and a full DEPTH-cycle clear restarts.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-enabled data memory with handshaked registered read/response port and a clear engine
module data_mem_unit #(
   parameter int WIDTH         = 32,
   parameter int RAM_ADDR_BITS = 12,
   parameter int ADDR_WIDTH    = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [WIDTH-1:0]        req_wdata,
   input  logic [WIDTH/8-1:0]      req_be,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err,
   input  logic                    clear_start,
   output logic                    busy
);
   localparam int DEPTH = 2**RAM_ADDR_BITS;
   localparam int NBE   = WIDTH/8;
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t                   state_q;
   logic [RAM_ADDR_BITS-1:0] cnt_q;
   logic [WIDTH-1:0]         mem_q [DEPTH];
   logic [WIDTH-1:0]         rsp_data_q;
   logic                     rsp_valid_q, rsp_err_q;
   logic                     in_range, accept;
   logic [RAM_ADDR_BITS-1:0] idx;
   assign idx = req_addr[RAM_ADDR_BITS-1:0];
   generate
      if (ADDR_WIDTH > RAM_ADDR_BITS) begin : g_range
         assign in_range = req_addr[ADDR_WIDTH-1:RAM_ADDR_BITS] == '0;
      end else begin : g_full
         assign in_range = 1'b1;
      end
   endgenerate
   assign busy      = state_q == CLEAR;
   assign req_ready = state_q == IDLE && !clear_start && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   // Array write port: the clear engine zeroes one word per cycle, otherwise accepted in-range writes update enabled lanes
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) mem_q[cnt_q] <= '0;
      else if (accept && req_write && in_range)
         for (int i = 0; i < NBE; i++)
            if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
   end
   // Clear/idle control and the response register, which loads on accept and drains on rsp_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (state_q == CLEAR) begin
            cnt_q <= cnt_q + RAM_ADDR_BITS'(1);
            if (&cnt_q) state_q <= IDLE;
         end else if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
         end
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (!req_write && in_range) ? mem_q[idx] : '0;
            rsp_err_q   <= !in_range;
         end else if (rsp_ready) rsp_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: randomized and directed checks of data_mem_unit against a word-array reference model
module tb_data_mem_unit;
   localparam int W = 32, RB = 12, AW = 14, DEPTH = 4096;
   logic          clk = 0, rst_n = 0, req_valid = 0, req_write = 0, rsp_ready = 1, clear_start = 0;
   logic [AW-1:0] req_addr = '0;
   logic [W-1:0]  req_wdata = '0;
   logic [3:0]    req_be = '0;
   logic          req_ready, rsp_valid, rsp_err, busy;
   logic [W-1:0]  rsp_data;
   int            checks = 0, errors = 0;
   logic [31:0]   model [DEPTH];

   data_mem_unit #(.WIDTH(W), .RAM_ADDR_BITS(RB), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .clear_start(clear_start), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endfunction

   // reference: returns {err, data} of the response and applies a write to the model
   function automatic logic [32:0] expect_rsp(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] m;
      int          k;
      if (int'(a) >= DEPTH) return {1'b1, 32'h0};
      k = int'(a);
      if (!w) return {1'b0, model[k]};
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      model[k] = (model[k] & ~m) | (d & m);
      return {1'b0, 32'h0};
   endfunction

   // drive one request with rsp_ready high and return once it has been accepted
   task automatic send(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be, output int waited);
      req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be; rsp_ready = 1; waited = 0;
      #1;
      while (!req_ready && waited < 3*DEPTH) begin
         tick();
         waited++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout addr %h waited %0d", a, waited);
      end
      @(posedge clk);
      #1;
      req_valid = 0;
   endtask

   task automatic test_reset();
      int n = 0;
      int addrs[3] = '{0, 1, DEPTH-1};
      int wt;
      logic [32:0] e;
      rst_n = 0;
      repeat (3) tick();
      checks++;
      if ({busy, req_ready, rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_values got busy %b rdy %b vld %b err %b data %h", busy, req_ready, rsp_valid, rsp_err, rsp_data);
      end
      model_clear();
      rst_n = 1;
      while (busy === 1'b1 && n < DEPTH + 10) begin
         tick();
         n++;
      end
      checks++;
      if (n !== DEPTH || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_clear_len got %0d cycles rdy %b exp %0d cycles rdy 1", n, req_ready, DEPTH);
      end
      foreach (addrs[i]) begin
         send(0, AW'(addrs[i]), 0, 0, wt);
         e = expect_rsp(0, AW'(addrs[i]), 0, 0);
         checks++;
         if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
            errors++;
            $display("FAIL reset_read addr %0d got v%b %b %h exp %b %h", addrs[i], rsp_valid, rsp_err, rsp_data, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_byte_lanes();
      int wt;
      logic [32:0] e;
      send(1, 5, 32'hDEADBEEF, 4'hF, wt);
      e = expect_rsp(1, 5, 32'hDEADBEEF, 4'hF);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL write_full_rsp got v%b %b %h exp 1 %b %h", rsp_valid, rsp_err, rsp_data, e[32], e[31:0]);
      end
      send(1, 5, 32'h000000AA, 4'h1, wt);
      e = expect_rsp(1, 5, 32'h000000AA, 4'h1);
      send(0, 5, 0, 0, wt);
      e = expect_rsp(0, 5, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'hDEADBEAA || e[31:0] !== 32'hDEADBEAA) begin
         errors++;
         $display("FAIL byte_lane_read got v%b %b %h exp 1 0 deadbeaa", rsp_valid, rsp_err, rsp_data);
      end
      send(1, 5, 32'hFFFFFFFF, 4'h0, wt);
      e = expect_rsp(1, 5, 32'hFFFFFFFF, 4'h0);
      send(0, 5, 0, 0, wt);
      e = expect_rsp(0, 5, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL zero_be_write got v%b %b %h exp %b %h", rsp_valid, rsp_err, rsp_data, e[32], e[31:0]);
      end
   endtask

   task automatic test_range();
      int wt;
      logic [32:0] e;
      send(0, 14'h1000, 0, 0, wt);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL oor_read got v%b %b %h exp 1 1 00000000", rsp_valid, rsp_err, rsp_data);
      end
      send(1, 14'h1005, 32'h12345678, 4'hF, wt);
      e = expect_rsp(1, 14'h1005, 32'h12345678, 4'hF);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL oor_write got v%b %b %h exp 1 1 00000000", rsp_valid, rsp_err, rsp_data);
      end
      send(0, 14'h0005, 0, 0, wt);
      e = expect_rsp(0, 14'h0005, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL oor_alias_read got %b %h exp %b %h", rsp_err, rsp_data, e[32], e[31:0]);
      end
   endtask

   task automatic test_random();
      int wt;
      bit w;
      logic [AW-1:0] a;
      logic [31:0] d;
      logic [3:0] be;
      logic [32:0] e;
      for (int k = 0; k < 300; k++) begin
         w  = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         send(w, a, d, be, wt);
         e = expect_rsp(w, a, d, be);
         checks++;
         if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
            errors++;
            $display("FAIL random_%0d w%b addr %h got v%b %b %h exp %b %h", k, w, a, rsp_valid, rsp_err, rsp_data, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int wt;
      logic [AW-1:0] a;
      logic [31:0] d;
      logic [32:0] e;
      for (int k = 0; k < 4; k++) begin
         a = AW'($urandom_range(0, DEPTH-1));
         d = $urandom;
         send(1, a, d, 4'hF, wt);
         e = expect_rsp(1, a, d, 4'hF);
         send(0, a, 0, 0, wt);
         e = expect_rsp(0, a, 0, 0);
         checks++;
         if (wt !== 0 || rsp_valid !== 1'b1 || rsp_data !== d || e[31:0] !== d) begin
            errors++;
            $display("FAIL raw_b2b addr %h got wait %0d data %h exp wait 0 data %h", a, wt, rsp_data, d);
         end
      end
   endtask

   task automatic test_backpressure();
      int wt;
      logic [32:0] e;
      send(1, 9, 32'hCAFE0001, 4'hF, wt);
      e = expect_rsp(1, 9, 32'hCAFE0001, 4'hF);
      send(0, 9, 0, 0, wt);
      e = expect_rsp(0, 9, 0, 0);
      rsp_ready = 0;
      req_valid = 1; req_write = 0; req_addr = 5;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE0001 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d got v%b data %h rdy %b exp v1 cafe0001 rdy 0", k, rsp_valid, rsp_data, req_ready);
         end
         tick();
      end
      rsp_ready = 1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready got %b exp 1", req_ready);
      end
      tick();
      req_valid = 0;
      e = expect_rsp(0, 5, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL consume_and_accept got v%b %b %h exp 1 %b %h", rsp_valid, rsp_err, rsp_data, e[32], e[31:0]);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain got v%b exp 0", rsp_valid);
      end
   endtask

   task automatic test_clear();
      int wt;
      int n = 0;
      logic [32:0] e;
      send(1, 7, 32'h11, 4'hF, wt);
      e = expect_rsp(1, 7, 32'h11, 4'hF);
      clear_start = 1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_start_ready got %b exp 0", req_ready);
      end
      rsp_ready = 0;
      tick();
      clear_start = 0;
      while (busy === 1'b1 && n < DEPTH + 50) begin
         clear_start = (n == 10);
         if (n == 20) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
               errors++;
               $display("FAIL pending_in_clear got v%b %b %h exp 1 0 00000000", rsp_valid, rsp_err, rsp_data);
            end
            rsp_ready = 1;
         end
         tick();
         n++;
      end
      clear_start = 0;
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("FAIL clear_len got %0d exp %0d", n, DEPTH);
      end
      model_clear();
      send(0, 7, 0, 0, wt);
      e = expect_rsp(0, 7, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL read_after_clear got %b %h exp %b %h", rsp_err, rsp_data, e[32], e[31:0]);
      end
   endtask

   task automatic test_midclear_reset();
      int wt;
      int n = 0;
      logic [32:0] e;
      send(1, 3, 32'h55AA55AA, 4'hF, wt);
      e = expect_rsp(1, 3, 32'h55AA55AA, 4'hF);
      send(0, 3, 0, 0, wt);
      e = expect_rsp(0, 3, 0, 0);
      rsp_ready = 0;
      clear_start = 1;
      tick();
      clear_start = 0;
      repeat (100) tick();
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== e[31:0]) begin
         errors++;
         $display("FAIL pre_reset got busy %b v%b %h exp 1 1 %h", busy, rsp_valid, rsp_data, e[31:0]);
      end
      rst_n = 0;
      #1;
      checks++;
      if ({busy, rsp_valid, req_ready, rsp_err, rsp_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL async_reset got busy %b v%b rdy %b err %b %h exp 1 0 0 0 0", busy, rsp_valid, req_ready, rsp_err, rsp_data);
      end
      tick();
      rst_n = 1;
      rsp_ready = 1;
      while (busy === 1'b1 && n < DEPTH + 50) begin
         tick();
         n++;
      end
      checks++;
      if (n !== DEPTH || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear_len got %0d v%b exp %0d v0", n, rsp_valid, DEPTH);
      end
      model_clear();
      send(0, 3, 0, 0, wt);
      e = expect_rsp(0, 3, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== e) begin
         errors++;
         $display("FAIL read_after_restart got %b %h exp %b %h", rsp_err, rsp_data, e[32], e[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_range();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_midclear_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
